// File: rtl/pnu_tdm_demux8.sv
// Receive-side 1:8 TDM demultiplexer: assembles serial slots into a shadow and
// publishes all eight channels at once. Define PNU_TDM_PARITY_EN for a 9-slot frame with even parity.
module pnu_tdm_demux8 #(
    parameter bit SYNC_REQUIRED = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_bit,
    input  logic in_valid,
    input  logic frame_sync,
    output logic o1,
    output logic o2,
    output logic o3,
    output logic o4,
    output logic o5,
    output logic o6,
    output logic o7,
    output logic o8,
    output logic out_valid,
    output logic e1,
    output logic e2,
    output logic e3,
`ifdef PNU_TDM_PARITY_EN
    output logic parity_err,
`endif
    output logic sync_err
);

`ifdef PNU_TDM_PARITY_EN
    localparam int CW    = 4;
    localparam int FRAME = 9;
`else
    localparam int CW    = 3;
    localparam int FRAME = 8;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    shadow;
    logic [7:0]    shadow_nxt;
    logic [7:0]    chan;

    // Shadow with the current bit dropped into its slot; the parity slot is never stored.
    always_comb begin
        shadow_nxt = shadow;
`ifdef PNU_TDM_PARITY_EN
        if (!cnt[3]) shadow_nxt[cnt[2:0]] = in_bit;
`else
        shadow_nxt[cnt] = in_bit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SYNC_REQUIRED ? HUNT : RECV;
            cnt       <= '0;
            shadow    <= '0;
            chan      <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
`ifdef PNU_TDM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
`ifdef PNU_TDM_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow <= {7'b0, in_bit};
                            cnt    <= CW'(1);
                            state  <= RECV;
                        end
                    end
                    RECV: begin
                        if (frame_sync && cnt != '0) begin
                            // Misplaced marker: drop the partial frame and realign on this bit.
                            sync_err <= 1'b1;
                            shadow   <= {7'b0, in_bit};
                            cnt      <= CW'(1);
                        end else if (cnt == LAST) begin
                            shadow <= shadow_nxt;
                            cnt    <= '0;
`ifdef PNU_TDM_PARITY_EN
                            if (^{shadow, in_bit} == 1'b0) begin
                                chan      <= shadow;
                                out_valid <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
`else
                            chan      <= shadow_nxt;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            shadow <= shadow_nxt;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign {o8, o7, o6, o5, o4, o3, o2, o1} = chan;
    assign {e1, e2, e3} = cnt[2:0];

endmodule
